lcd1602_ctrl: RTL
=================

LCD1602_CTRL -- requirements
Module: lcd1602_ctrl

Interface
REQ-001 Parameter PWR_DLY_CYC, default 750000: power-on wait before the first command, in Clk cycles (15 ms at 50 MHz).
REQ-002 Parameter CLR_DLY_CYC, default 100000: extra wait after the clear-display command, in Clk cycles (2 ms at 50 MHz).
REQ-003 Clk  input  1  system clock; all logic on posedge Clk.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 char_we  input  1  host write strobe into the character buffer.
REQ-006 char_addr  input  5  buffer index; 0-15 = line 0 columns 0-15, 16-31 = line 1 columns 0-15.
REQ-007 char_data  input  8  ASCII code to store.
REQ-008 wr_cmd  output  1  one-cycle request to the downstream driver: write command byte.
REQ-009 wr_data  output  1  one-cycle request to the downstream driver: write display data byte.
REQ-010 data  output  8  byte for the current request.
REQ-011 wr_done  input  1  one-cycle completion pulse from the downstream driver.
REQ-012 init_done  output  1  high once the init sequence has completed; low otherwise.

Function
REQ-013 Buffer: 32 x 8 registers, written at posedge Clk when char_we=1; char_we is accepted every cycle in every state.
REQ-014 States: PWR_WAIT, INIT_REQ, INIT_WAIT, CLR_WAIT, ADDR_REQ, ADDR_WAIT, CHAR_REQ, CHAR_WAIT.
REQ-015 PWR_WAIT: count PWR_DLY_CYC cycles, then go to INIT_REQ with init index = 0.
REQ-016 Init command list, in order: 0x38, 0x0C, 0x06, 0x01.
REQ-017 INIT_REQ: pulse wr_cmd for exactly one cycle with data = list[index], then go to INIT_WAIT.
REQ-018 INIT_WAIT: hold until wr_done=1.
  - index < 3: index+1, back to INIT_REQ.
  - index = 3: go to CLR_WAIT.
REQ-019 CLR_WAIT: count CLR_DLY_CYC cycles, set init_done=1, go to ADDR_REQ with line = 0.
REQ-020 ADDR_REQ: pulse wr_cmd with data = 0x80 (line 0) or 0xC0 (line 1), then go to ADDR_WAIT.
REQ-021 ADDR_WAIT: on wr_done, go to CHAR_REQ with column = 0.
REQ-022 CHAR_REQ: pulse wr_data with data = buffer[line*16 + column], then go to CHAR_WAIT.
REQ-023 CHAR_WAIT: on wr_done:
  - column < 15: column+1, back to CHAR_REQ.
  - column = 15: toggle line, go to ADDR_REQ.
  - Refresh repeats indefinitely: line 1 wraps to line 0.
REQ-024 Issue latency: the next request pulse comes exactly 1 cycle after the wr_done cycle. Request-to-request spacing is therefore driver latency + 1.
REQ-025 data is registered and changes only in the cycle its request pulse is asserted; it is held stable until the next request.
REQ-026 wr_cmd and wr_data are never high together; at most one request is outstanding at any time.
REQ-027 wr_done arriving in any state other than a *_WAIT state is ignored.
REQ-028 Simultaneous char_we to the byte being sampled in CHAR_REQ: the old value is sent; the new value appears on the next refresh pass.
REQ-029 Delay counters are wide enough for their parameter value; a parameter value of 0 or 1 yields a 1-cycle wait.
REQ-030 init_done, once set, stays high until reset.

Reset
REQ-031 Rst=1 forces, asynchronously:
  - state=PWR_WAIT, all counters and indices=0
  - wr_cmd=0, wr_data=0, data=0x00, init_done=0
  - every buffer byte=0x20 (space)
REQ-032 Reset mid-transaction abandons the outstanding request. After release, the full power-on wait and init sequence run again. A stale wr_done arriving during PWR_WAIT is ignored.

Verification (PWR_DLY_CYC=20, CLR_DLY_CYC=10, driver model returns wr_done N cycles after each request)
REQ-033 Release reset -> no request for 20 cycles; then wr_cmd pulses carry 0x38, 0x0C, 0x06, 0x01, each issued 1 cycle after the previous wr_done; init_done rises 10 cycles after the fourth wr_done.
REQ-034 No host writes -> after init: wr_cmd 0x80, 16 x wr_data 0x20, wr_cmd 0xC0, 16 x wr_data 0x20, then 0x80 again.
REQ-035 Write 0x41 to addr 0 and 0x5A to addr 31 before init completes -> first refresh sends 0x41 right after 0x80 and 0x5A as the last byte after 0xC0.
REQ-036 char_we to addr 5 with 0x42 in the same cycle CHAR_REQ samples addr 5 (old 0x20) -> 0x20 is sent on this pass, 0x42 on the next pass.
REQ-037 Spurious wr_done during PWR_WAIT and CLR_WAIT -> no state advance and no request pulse; timing matches REQ-033.
REQ-038 Assert Rst while in CHAR_WAIT of line 1 -> outputs go to 0 immediately and the buffer reads all 0x20; after release the REQ-033 sequence repeats exactly.

Source files
------------

// File: rtl/lcd1602_ctrl.sv
// HD44780-style 16x2 LCD controller: power-on wait, init command list, then endless refresh from a 32-byte buffer.
// Latency: each request pulse follows the driver's wr_done by exactly one cycle; delays are PWR_DLY_CYC / CLR_DLY_CYC cycles.
// Backpressure: one request outstanding at a time; the FSM holds in *_WAIT until the downstream driver returns wr_done.
module lcd1602_ctrl #(
    parameter int PWR_DLY_CYC = 750000,
    parameter int CLR_DLY_CYC = 100000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       char_we,
    input  logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic       wr_cmd,
    output logic       wr_data,
    output logic [7:0] data,
    input  logic       wr_done,
    output logic       init_done
);

    // One shared delay counter serves both waits, so size it for the longer one.
    localparam int MAX_DLY = (PWR_DLY_CYC > CLR_DLY_CYC) ? PWR_DLY_CYC : CLR_DLY_CYC;
    localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

    // Terminal counts; 0 and 1 both collapse to a single-cycle wait.
    localparam logic [CNT_W-1:0] PWR_LAST = (PWR_DLY_CYC > 1) ? CNT_W'(PWR_DLY_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CLR_LAST = (CLR_DLY_CYC > 1) ? CNT_W'(CLR_DLY_CYC - 1) : '0;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_REQ,
        INIT_WAIT,
        CLR_WAIT,
        ADDR_REQ,
        ADDR_WAIT,
        CHAR_REQ,
        CHAR_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] dly_cnt;
    logic [1:0]       init_idx;
    logic             line;
    logic [3:0]       col;
    logic [7:0]       char_buf [32];

    // Function set 8-bit/2-line, display on, entry mode increment, clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h06;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    // Character buffer: host writes land every cycle regardless of FSM state; reset fills with spaces.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) begin
                char_buf[i] <= 8'h20;
            end
        end else if (char_we) begin
            char_buf[char_addr] <= char_data;
        end
    end

    // Sequencer: the request strobe and its data byte are loaded on the edge that enters a *_REQ state,
    // so the pulse coincides with the REQ state and lands one cycle after the wr_done that triggered it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= PWR_WAIT;
            dly_cnt   <= '0;
            init_idx  <= 2'd0;
            line      <= 1'b0;
            col       <= 4'd0;
            wr_cmd    <= 1'b0;
            wr_data   <= 1'b0;
            data      <= 8'h00;
            init_done <= 1'b0;
        end else begin
            wr_cmd  <= 1'b0;
            wr_data <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    if (dly_cnt == PWR_LAST) begin
                        dly_cnt  <= '0;
                        init_idx <= 2'd0;
                        state    <= INIT_REQ;
                        wr_cmd   <= 1'b1;
                        data     <= init_cmd(2'd0);
                    end else begin
                        dly_cnt <= dly_cnt + CNT_W'(1);
                    end
                end
                INIT_REQ: begin
                    state <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (wr_done) begin
                        if (init_idx == 2'd3) begin
                            state <= CLR_WAIT;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                            state    <= INIT_REQ;
                            wr_cmd   <= 1'b1;
                            data     <= init_cmd(init_idx + 2'd1);
                        end
                    end
                end
                CLR_WAIT: begin
                    // Clear-display needs extra settling time before the first refresh.
                    if (dly_cnt == CLR_LAST) begin
                        dly_cnt   <= '0;
                        init_done <= 1'b1;
                        line      <= 1'b0;
                        state     <= ADDR_REQ;
                        wr_cmd    <= 1'b1;
                        data      <= 8'h80;
                    end else begin
                        dly_cnt <= dly_cnt + CNT_W'(1);
                    end
                end
                ADDR_REQ: begin
                    state <= ADDR_WAIT;
                end
                ADDR_WAIT: begin
                    if (wr_done) begin
                        col     <= 4'd0;
                        state   <= CHAR_REQ;
                        wr_data <= 1'b1;
                        data    <= char_buf[{line, 4'd0}];
                    end
                end
                CHAR_REQ: begin
                    state <= CHAR_WAIT;
                end
                CHAR_WAIT: begin
                    if (wr_done) begin
                        if (col == 4'd15) begin
                            // Line 1 wraps back to line 0 so the refresh never stops.
                            line   <= ~line;
                            state  <= ADDR_REQ;
                            wr_cmd <= 1'b1;
                            data   <= line ? 8'h80 : 8'hC0;
                        end else begin
                            col     <= col + 4'd1;
                            state   <= CHAR_REQ;
                            wr_data <= 1'b1;
                            data    <= char_buf[{line, col + 4'd1}];
                        end
                    end
                end
                default: begin
                    state <= PWR_WAIT;
                end
            endcase
        end
    end

endmodule
